reservation_station: RTL and testbench

//  Issue-stage reservation station for the out-of-order core. Buffers decoded, renamed instructions
//  in three per-unit queues (ALU, LSU, MUL) and tracks source-operand readiness via CDB tag broadcasts.

---
 rtl/reservation_station_if.sv | 70 +++++++
 rtl/reservation_station.sv | 206 ++++++++++++++++++++
 tb/tb_reservation_station.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/reservation_station_if.sv
// ----------------------------------------------------------------------------
// reservation_station_if
// Dispatch, wakeup and issue bundle of the reservation station.
//   master : rename/dispatch + execution-unit side (drives *_i, observes *_o)
//   slave  : the reservation station itself
// Signals:
//   rs_allocate_i, pc_i, inst_i, prs1/prs2/prd_addr_i  dispatch payload
//   alu/lsu/mul_request_i                              target queue select
//   prs1/prs2_valid_i                                  operand ready at dispatch
//   alu/lsu/mul_valid_i                                unit can accept
//   cdb_en_i, cdb_tag_i                                writeback broadcast
//   alu/lsu/mul_free_o                                 queue has a free slot
//   alu/lsu/mul_request_o + payload                    issued instruction
// ----------------------------------------------------------------------------
interface reservation_station_if #(
    parameter int TAG_W = 5
);
    logic             rs_allocate_i;
    logic [31:0]      pc_i;
    logic [31:0]      inst_i;
    logic [TAG_W-1:0] prs1_addr_i;
    logic [TAG_W-1:0] prs2_addr_i;
    logic [TAG_W-1:0] prd_addr_i;
    logic             alu_request_i;
    logic             lsu_request_i;
    logic             mul_request_i;
    logic             prs1_valid_i;
    logic             prs2_valid_i;
    logic             alu_valid_i;
    logic             lsu_valid_i;
    logic             mul_valid_i;
    logic             cdb_en_i;
    logic [TAG_W-1:0] cdb_tag_i;

    logic             alu_free_o;
    logic             lsu_free_o;
    logic             mul_free_o;
    logic             alu_request_o;
    logic             lsu_request_o;
    logic             mul_request_o;
    logic [31:0]      alu_pc_o,   lsu_pc_o,   mul_pc_o;
    logic [31:0]      alu_inst_o, lsu_inst_o, mul_inst_o;
    logic [TAG_W-1:0] alu_prs1_addr_o, lsu_prs1_addr_o, mul_prs1_addr_o;
    logic [TAG_W-1:0] alu_prs2_addr_o, lsu_prs2_addr_o, mul_prs2_addr_o;
    logic [TAG_W-1:0] alu_prd_addr_o,  lsu_prd_addr_o,  mul_prd_addr_o;

    modport master (
        output rs_allocate_i, pc_i, inst_i, prs1_addr_i, prs2_addr_i, prd_addr_i,
               alu_request_i, lsu_request_i, mul_request_i, prs1_valid_i, prs2_valid_i,
               alu_valid_i, lsu_valid_i, mul_valid_i, cdb_en_i, cdb_tag_i,
        input  alu_free_o, lsu_free_o, mul_free_o,
               alu_request_o, lsu_request_o, mul_request_o,
               alu_pc_o, lsu_pc_o, mul_pc_o, alu_inst_o, lsu_inst_o, mul_inst_o,
               alu_prs1_addr_o, lsu_prs1_addr_o, mul_prs1_addr_o,
               alu_prs2_addr_o, lsu_prs2_addr_o, mul_prs2_addr_o,
               alu_prd_addr_o, lsu_prd_addr_o, mul_prd_addr_o
    );

    modport slave (
        input  rs_allocate_i, pc_i, inst_i, prs1_addr_i, prs2_addr_i, prd_addr_i,
               alu_request_i, lsu_request_i, mul_request_i, prs1_valid_i, prs2_valid_i,
               alu_valid_i, lsu_valid_i, mul_valid_i, cdb_en_i, cdb_tag_i,
        output alu_free_o, lsu_free_o, mul_free_o,
               alu_request_o, lsu_request_o, mul_request_o,
               alu_pc_o, lsu_pc_o, mul_pc_o, alu_inst_o, lsu_inst_o, mul_inst_o,
               alu_prs1_addr_o, lsu_prs1_addr_o, mul_prs1_addr_o,
               alu_prs2_addr_o, lsu_prs2_addr_o, mul_prs2_addr_o,
               alu_prd_addr_o, lsu_prd_addr_o, mul_prd_addr_o
    );
endinterface

// File: rtl/reservation_station.sv
// ----------------------------------------------------------------------------
// reservation_station
// Issue-stage reservation station with three independent per-unit queues
// (ALU, LSU, MUL). Tracks operand readiness from CDB broadcasts and issues
// the oldest ready entry of each queue when its unit can accept.
// Ports:
//   clk_i    rising-edge clock
//   reset_i  asynchronous active-low reset
//   rs       reservation_station_if.slave (dispatch, CDB, issue, free flags)
// RsQueue is the per-unit queue: a compacting buffer where index 0 is always
// the oldest entry, so "oldest ready" is simply the lowest ready index.
// ----------------------------------------------------------------------------
module RsQueue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             alloc_i,
    input  logic [31:0]      pc_i,
    input  logic [31:0]      inst_i,
    input  logic [TAG_W-1:0] prs1_i,
    input  logic [TAG_W-1:0] prs2_i,
    input  logic [TAG_W-1:0] prd_i,
    input  logic             rdy1_i,
    input  logic             rdy2_i,
    input  logic             cdb_en_i,
    input  logic [TAG_W-1:0] cdb_tag_i,
    input  logic             unit_valid_i,
    output logic             free_o,
    output logic             request_o,
    output logic [31:0]      pc_o,
    output logic [31:0]      inst_o,
    output logic [TAG_W-1:0] prs1_o,
    output logic [TAG_W-1:0] prs2_o,
    output logic [TAG_W-1:0] prd_o
);
    typedef struct packed {
        logic             valid;
        logic [31:0]      pc;
        logic [31:0]      inst;
        logic [TAG_W-1:0] prs1;
        logic [TAG_W-1:0] prs2;
        logic [TAG_W-1:0] prd;
        logic             rdy1;
        logic             rdy2;
    } entry_t;

    entry_t ent_q     [DEPTH];
    entry_t ent_d     [DEPTH];
    entry_t woke      [DEPTH];
    entry_t shifted   [DEPTH];

    logic             request_d;
    logic             hasCand;
    int               issueIdx;
    logic             placed;
    logic [31:0]      pc_q, inst_q;
    logic [TAG_W-1:0] prs1_q, prs2_q, prd_q;
    logic [31:0]      issPc, issInst;
    logic [TAG_W-1:0] issPrs1, issPrs2, issPrd;

    // Valid entries are kept contiguous from index 0, so the last slot being
    // empty is exactly "at least one slot free".
    assign free_o = ~ent_q[DEPTH-1].valid;

    always_comb begin
        hasCand  = 1'b0;
        issueIdx = 0;
        issPc    = '0;
        issInst  = '0;
        issPrs1  = '0;
        issPrs2  = '0;
        issPrd   = '0;
        // Descending scan: the last hit is the lowest index, i.e. the oldest.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_q[i].valid && ent_q[i].rdy1 && ent_q[i].rdy2) begin
                hasCand  = 1'b1;
                issueIdx = i;
                issPc    = ent_q[i].pc;
                issInst  = ent_q[i].inst;
                issPrs1  = ent_q[i].prs1;
                issPrs2  = ent_q[i].prs2;
                issPrd   = ent_q[i].prd;
            end
        end
        request_d = hasCand & unit_valid_i;

        for (int i = 0; i < DEPTH; i++) begin
            woke[i] = ent_q[i];
            if (cdb_en_i && ent_q[i].prs1 == cdb_tag_i) woke[i].rdy1 = 1'b1;
            if (cdb_en_i && ent_q[i].prs2 == cdb_tag_i) woke[i].rdy2 = 1'b1;
        end

        for (int i = 0; i < DEPTH - 1; i++) begin
            shifted[i] = woke[i + 1];
        end
        shifted[DEPTH-1] = '0;

        // Removing the issued entry shifts everything younger down one slot,
        // which keeps age order intact without an age matrix.
        for (int i = 0; i < DEPTH; i++) begin
            if (request_d && i >= issueIdx) ent_d[i] = shifted[i];
            else                            ent_d[i] = woke[i];
        end

        // Gated by the pre-edge free flag, so a slot freed by this edge's
        // issue is not reused until the next edge.
        placed = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc_i && free_o && !placed && !ent_d[i].valid) begin
                ent_d[i].valid = 1'b1;
                ent_d[i].pc    = pc_i;
                ent_d[i].inst  = inst_i;
                ent_d[i].prs1  = prs1_i;
                ent_d[i].prs2  = prs2_i;
                ent_d[i].prd   = prd_i;
                ent_d[i].rdy1  = rdy1_i;
                ent_d[i].rdy2  = rdy2_i;
                placed         = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            request_o <= 1'b0;
            pc_q      <= '0;
            inst_q    <= '0;
            prs1_q    <= '0;
            prs2_q    <= '0;
            prd_q     <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            request_o <= request_d;
            if (request_d) begin
                pc_q   <= issPc;
                inst_q <= issInst;
                prs1_q <= issPrs1;
                prs2_q <= issPrs2;
                prd_q  <= issPrd;
            end
        end
    end

    assign pc_o   = pc_q;
    assign inst_o = inst_q;
    assign prs1_o = prs1_q;
    assign prs2_o = prs2_q;
    assign prd_o  = prd_q;
endmodule

module reservation_station #(
    parameter int ALU_DEPTH = 4,
    parameter int LSU_DEPTH = 4,
    parameter int MUL_DEPTH = 2,
    parameter int TAG_W     = 5
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    reservation_station_if.slave  rs
);
    logic selAlu, selLsu, selMul;
    logic rdy1, rdy2;

    // Priority ALU > LSU > MUL; a full selected queue drops the request
    // rather than redirecting it to another queue.
    assign selAlu = rs.rs_allocate_i & rs.alu_request_i;
    assign selLsu = rs.rs_allocate_i & ~rs.alu_request_i & rs.lsu_request_i;
    assign selMul = rs.rs_allocate_i & ~rs.alu_request_i & ~rs.lsu_request_i & rs.mul_request_i;

    // Same-cycle CDB bypass so a tag broadcast during dispatch is not missed.
    assign rdy1 = rs.prs1_valid_i | (rs.cdb_en_i & (rs.cdb_tag_i == rs.prs1_addr_i));
    assign rdy2 = rs.prs2_valid_i | (rs.cdb_en_i & (rs.cdb_tag_i == rs.prs2_addr_i));

    RsQueue #(.DEPTH(ALU_DEPTH), .TAG_W(TAG_W)) aluQ (
        .clk_i(clk_i), .reset_i(reset_i), .alloc_i(selAlu),
        .pc_i(rs.pc_i), .inst_i(rs.inst_i), .prs1_i(rs.prs1_addr_i),
        .prs2_i(rs.prs2_addr_i), .prd_i(rs.prd_addr_i), .rdy1_i(rdy1), .rdy2_i(rdy2),
        .cdb_en_i(rs.cdb_en_i), .cdb_tag_i(rs.cdb_tag_i), .unit_valid_i(rs.alu_valid_i),
        .free_o(rs.alu_free_o), .request_o(rs.alu_request_o), .pc_o(rs.alu_pc_o),
        .inst_o(rs.alu_inst_o), .prs1_o(rs.alu_prs1_addr_o), .prs2_o(rs.alu_prs2_addr_o),
        .prd_o(rs.alu_prd_addr_o)
    );

    RsQueue #(.DEPTH(LSU_DEPTH), .TAG_W(TAG_W)) lsuQ (
        .clk_i(clk_i), .reset_i(reset_i), .alloc_i(selLsu),
        .pc_i(rs.pc_i), .inst_i(rs.inst_i), .prs1_i(rs.prs1_addr_i),
        .prs2_i(rs.prs2_addr_i), .prd_i(rs.prd_addr_i), .rdy1_i(rdy1), .rdy2_i(rdy2),
        .cdb_en_i(rs.cdb_en_i), .cdb_tag_i(rs.cdb_tag_i), .unit_valid_i(rs.lsu_valid_i),
        .free_o(rs.lsu_free_o), .request_o(rs.lsu_request_o), .pc_o(rs.lsu_pc_o),
        .inst_o(rs.lsu_inst_o), .prs1_o(rs.lsu_prs1_addr_o), .prs2_o(rs.lsu_prs2_addr_o),
        .prd_o(rs.lsu_prd_addr_o)
    );

    RsQueue #(.DEPTH(MUL_DEPTH), .TAG_W(TAG_W)) mulQ (
        .clk_i(clk_i), .reset_i(reset_i), .alloc_i(selMul),
        .pc_i(rs.pc_i), .inst_i(rs.inst_i), .prs1_i(rs.prs1_addr_i),
        .prs2_i(rs.prs2_addr_i), .prd_i(rs.prd_addr_i), .rdy1_i(rdy1), .rdy2_i(rdy2),
        .cdb_en_i(rs.cdb_en_i), .cdb_tag_i(rs.cdb_tag_i), .unit_valid_i(rs.mul_valid_i),
        .free_o(rs.mul_free_o), .request_o(rs.mul_request_o), .pc_o(rs.mul_pc_o),
        .inst_o(rs.mul_inst_o), .prs1_o(rs.mul_prs1_addr_o), .prs2_o(rs.mul_prs2_addr_o),
        .prd_o(rs.mul_prd_addr_o)
    );
endmodule

// File: tb/tb_reservation_station.sv
// ----------------------------------------------------------------------------
// tb_reservation_station
// Directed bench for reservation_station. The stimulus thread pushes the
// expected issue (payload plus the edge number it must appear after) into a
// per-unit queue; a monitor pops and compares on every issue pulse.
// ----------------------------------------------------------------------------
module tb_reservation_station;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  prs1;
        logic [4:0]  prs2;
        logic [4:0]  prd;
        int          cyc;
    } exp_t;

    exp_t expAlu[$];
    exp_t expLsu[$];
    exp_t expMul[$];
    exp_t monE;

    reservation_station_if #(.TAG_W(5)) rsIf ();

    reservation_station #(
        .ALU_DEPTH(4), .LSU_DEPTH(4), .MUL_DEPTH(2), .TAG_W(5)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst_n),
        .rs      (rsIf)
    );

    always #5 clk = ~clk;

    // Edge counter: at a negedge, cyc is the number of rising edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, required);
        end
    endtask

    task automatic reportUnexpected(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: issue seen at edge %0d, none expected", name, cyc);
    endtask

    task automatic compareIssue(input string name, input exp_t e, input logic [31:0] pc,
                                input logic [31:0] inst, input logic [4:0] p1,
                                input logic [4:0] p2, input logic [4:0] pd);
        checkOutput({name, " edge"}, cyc, e.cyc);
        checkOutput({name, " pc"},   pc,   e.pc);
        checkOutput({name, " inst"}, inst, e.inst);
        checkOutput({name, " prs1"}, {27'd0, p1}, {27'd0, e.prs1});
        checkOutput({name, " prs2"}, {27'd0, p2}, {27'd0, e.prs2});
        checkOutput({name, " prd"},  {27'd0, pd}, {27'd0, e.prd});
    endtask

    always @(negedge clk) begin
        if (rsIf.alu_request_o === 1'b1) begin
            if (expAlu.size() == 0) reportUnexpected("alu");
            else begin
                monE = expAlu.pop_front();
                compareIssue("alu", monE, rsIf.alu_pc_o, rsIf.alu_inst_o,
                             rsIf.alu_prs1_addr_o, rsIf.alu_prs2_addr_o, rsIf.alu_prd_addr_o);
            end
        end
        if (rsIf.lsu_request_o === 1'b1) begin
            if (expLsu.size() == 0) reportUnexpected("lsu");
            else begin
                monE = expLsu.pop_front();
                compareIssue("lsu", monE, rsIf.lsu_pc_o, rsIf.lsu_inst_o,
                             rsIf.lsu_prs1_addr_o, rsIf.lsu_prs2_addr_o, rsIf.lsu_prd_addr_o);
            end
        end
        if (rsIf.mul_request_o === 1'b1) begin
            if (expMul.size() == 0) reportUnexpected("mul");
            else begin
                monE = expMul.pop_front();
                compareIssue("mul", monE, rsIf.mul_pc_o, rsIf.mul_inst_o,
                             rsIf.mul_prs1_addr_o, rsIf.mul_prs2_addr_o, rsIf.mul_prd_addr_o);
            end
        end
    end

    // Drives one dispatch/CDB vector at a negedge; edgeN is the rising edge
    // that will consume it.
    task automatic applyStimulus(input bit alloc, input bit [2:0] sel,
                                 input logic [31:0] pc, input logic [31:0] inst,
                                 input logic [4:0] p1, input logic [4:0] p2,
                                 input logic [4:0] pd, input bit v1, input bit v2,
                                 input bit cdbEn, input logic [4:0] cdbTag,
                                 output int edgeN);
        @(negedge clk);
        rsIf.rs_allocate_i = alloc;
        rsIf.alu_request_i = sel[2];
        rsIf.lsu_request_i = sel[1];
        rsIf.mul_request_i = sel[0];
        rsIf.pc_i          = pc;
        rsIf.inst_i        = inst;
        rsIf.prs1_addr_i   = p1;
        rsIf.prs2_addr_i   = p2;
        rsIf.prd_addr_i    = pd;
        rsIf.prs1_valid_i  = v1;
        rsIf.prs2_valid_i  = v2;
        rsIf.cdb_en_i      = cdbEn;
        rsIf.cdb_tag_i     = cdbTag;
        edgeN              = cyc + 1;
    endtask

    task automatic idle(input int n);
        int dummy;
        repeat (n) applyStimulus(0, 3'b000, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 5'd0, dummy);
    endtask

    task automatic cdb(input logic [4:0] tag);
        int dummy;
        applyStimulus(0, 3'b000, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 0, 0, 1, tag, dummy);
    endtask

    task automatic setUnits(input bit a, input bit l, input bit m);
        rsIf.alu_valid_i = a;
        rsIf.lsu_valid_i = l;
        rsIf.mul_valid_i = m;
    endtask

    task automatic expectIssue(input int unit, input logic [31:0] pc, input logic [31:0] inst,
                               input logic [4:0] p1, input logic [4:0] p2,
                               input logic [4:0] pd, input int c);
        exp_t e;
        e.pc = pc; e.inst = inst; e.prs1 = p1; e.prs2 = p2; e.prd = pd; e.cyc = c;
        case (unit)
            0:       expAlu.push_back(e);
            1:       expLsu.push_back(e);
            default: expMul.push_back(e);
        endcase
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " alu_request"}, {31'd0, rsIf.alu_request_o}, 32'd0);
        checkOutput({tag, " lsu_request"}, {31'd0, rsIf.lsu_request_o}, 32'd0);
        checkOutput({tag, " mul_request"}, {31'd0, rsIf.mul_request_o}, 32'd0);
        checkOutput({tag, " alu_free"},    {31'd0, rsIf.alu_free_o},    32'd1);
        checkOutput({tag, " lsu_free"},    {31'd0, rsIf.lsu_free_o},    32'd1);
        checkOutput({tag, " mul_free"},    {31'd0, rsIf.mul_free_o},    32'd1);
        checkOutput({tag, " alu_pc"},      rsIf.alu_pc_o,               32'd0);
    endtask

    initial begin
        int e0, e1, x;
        setUnits(0, 0, 0);
        rsIf.rs_allocate_i = 0; rsIf.alu_request_i = 0; rsIf.lsu_request_i = 0;
        rsIf.mul_request_i = 0; rsIf.pc_i = 0; rsIf.inst_i = 0; rsIf.prs1_addr_i = 0;
        rsIf.prs2_addr_i = 0; rsIf.prd_addr_i = 0; rsIf.prs1_valid_i = 0;
        rsIf.prs2_valid_i = 0; rsIf.cdb_en_i = 0; rsIf.cdb_tag_i = 0;

        $display("[TB] reset");
        repeat (3) @(negedge clk);
        checkIdleOutputs("in reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkIdleOutputs("after release");

        $display("[TB] ALU wakeup via two CDB tags");
        applyStimulus(1, 3'b100, 32'h10, 32'h0000_0A13, 5'd2, 5'd3, 5'd0, 0, 0, 0, 5'd0, e0);
        setUnits(1, 0, 0);
        expectIssue(0, 32'h10, 32'h0000_0A13, 5'd2, 5'd3, 5'd0, e0 + 3);
        cdb(5'd2);
        cdb(5'd3);
        idle(4);

        $display("[TB] MUL same-cycle bypass");
        setUnits(0, 0, 1);
        applyStimulus(1, 3'b001, 32'h30, 32'h0230_0033, 5'd4, 5'd5, 5'd6, 1, 0, 1, 5'd5, e0);
        expectIssue(2, 32'h30, 32'h0230_0033, 5'd4, 5'd5, 5'd6, e0 + 1);
        idle(3);

        $display("[TB] ALU fill and drain");
        setUnits(0, 0, 0);
        for (int k = 0; k < 4; k++)
            applyStimulus(1, 3'b100, 32'h40 + k, 32'h100 + k, 5'd1, 5'd1, 5'd8 + k[4:0],
                          1, 1, 0, 5'd0, e0);
        applyStimulus(1, 3'b100, 32'h44, 32'h104, 5'd1, 5'd1, 5'd12, 1, 1, 0, 5'd0, e0);
        checkOutput("alu_free when full", {31'd0, rsIf.alu_free_o}, 32'd0);
        idle(0);
        applyStimulus(0, 3'b000, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 5'd0, x);
        checkOutput("alu_free after dropped alloc", {31'd0, rsIf.alu_free_o}, 32'd0);
        setUnits(1, 0, 0);
        for (int k = 0; k < 4; k++)
            expectIssue(0, 32'h40 + k, 32'h100 + k, 5'd1, 5'd1, 5'd8 + k[4:0], x + k);
        idle(1);
        checkOutput("alu_free after first drain", {31'd0, rsIf.alu_free_o}, 32'd1);
        idle(3);
        checkOutput("alu_free after drain", {31'd0, rsIf.alu_free_o}, 32'd1);

        $display("[TB] oldest ready first");
        applyStimulus(1, 3'b100, 32'h50, 32'h500, 5'd7, 5'd9, 5'd10, 0, 1, 0, 5'd0, e0);
        applyStimulus(1, 3'b100, 32'h51, 32'h501, 5'd1, 5'd2, 5'd11, 1, 1, 0, 5'd0, e1);
        expectIssue(0, 32'h51, 32'h501, 5'd1, 5'd2, 5'd11, e1 + 1);
        expectIssue(0, 32'h50, 32'h500, 5'd7, 5'd9, 5'd10, e1 + 3);
        idle(1);
        cdb(5'd7);
        idle(3);

        $display("[TB] queue select priority");
        setUnits(0, 1, 1);
        applyStimulus(1, 3'b011, 32'h60, 32'h600, 5'd3, 5'd4, 5'd13, 1, 1, 0, 5'd0, e0);
        expectIssue(1, 32'h60, 32'h600, 5'd3, 5'd4, 5'd13, e0 + 1);
        setUnits(1, 1, 1);
        applyStimulus(1, 3'b110, 32'h61, 32'h601, 5'd3, 5'd4, 5'd14, 1, 1, 0, 5'd0, e1);
        expectIssue(0, 32'h61, 32'h601, 5'd3, 5'd4, 5'd14, e1 + 1);
        applyStimulus(0, 3'b100, 32'h62, 32'h602, 5'd3, 5'd4, 5'd15, 1, 1, 0, 5'd0, e0);
        idle(3);

        $display("[TB] async reset mid-operation");
        setUnits(0, 0, 0);
        applyStimulus(1, 3'b100, 32'h70, 32'h700, 5'd1, 5'd2, 5'd16, 1, 1, 0, 5'd0, e0);
        applyStimulus(1, 3'b100, 32'h71, 32'h701, 5'd1, 5'd2, 5'd17, 1, 1, 0, 5'd0, e0);
        applyStimulus(0, 3'b000, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 5'd0, x);
        setUnits(1, 0, 0);
        expectIssue(0, 32'h70, 32'h700, 5'd1, 5'd2, 5'd16, x);
        @(negedge clk);
        #1;
        checkOutput("alu_request before reset", {31'd0, rsIf.alu_request_o}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        checkIdleOutputs("async reset");
        checkOutput("alu_prd in reset", {27'd0, rsIf.alu_prd_addr_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        checkOutput("alu_free after reset", {31'd0, rsIf.alu_free_o}, 32'd1);

        checkOutput("alu pending issues", expAlu.size(), 32'd0);
        checkOutput("lsu pending issues", expLsu.size(), 32'd0);
        checkOutput("mul pending issues", expMul.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
